bcd_converter: RTL and testbench

Sequential binary-to-BCD converter that runs the shift-and-add-3 (double dabble) algorithm, one bit per clock.
- Sits directly upstream of the 6-digit seven-segment output stage: takes a DATA_WIDTH-bit value from the CPU bus and produces a 4*DIGITS-bit packed BCD word.
- The display stage shows hexadecimal; with this block in front of it, the panel shows decimal.
- Uses a one-cycle load/valid handshake. The result is held stable between conversions so the display never sees intermediate values.

---
 rtl/bcd_pkg.sv | 23 ++
 rtl/bcd_converter_if.sv | 47 ++++
 rtl/bcd_digit_adjust.sv | 19 +
 rtl/bcd_converter.sv | 139 +++++++++++++
 tb/tb_bcd_converter.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the binary-to-BCD converter.
//   state_t            : converter FSM states (IDLE, SHIFT, DONE)
//   BCD_ADJ_THRESHOLD  : nibble value at or above which +3 is applied
//   BCD_ADJ_ADD        : correction added to a nibble before each shift
//   BCD_NINE           : digit value used when the result saturates
//   cnt_width()        : width of a counter that must hold 0..data_width
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] BCD_ADJ_THRESHOLD = 4'd5;
    localparam logic [3:0] BCD_ADJ_ADD       = 4'd3;
    localparam logic [3:0] BCD_NINE          = 4'h9;

    function automatic int cnt_width(input int data_width);
        return $clog2(data_width + 1);
    endfunction

endpackage

// File: rtl/bcd_converter_if.sv
// Bus between the CPU-side load logic and the BCD converter.
//   i_BUS      : binary operand, sampled only when a load is accepted
//   i_LOAD     : start-conversion strobe
//   o_BUSY     : conversion in progress (SHIFT state)
//   o_VALID    : one-cycle pulse, o_BCD was just updated
//   o_BCD      : packed BCD result, digit 0 in the low nibble
//   o_OVERFLOW : last result did not fit in DIGITS digits
//   o_NEGATIVE : sign of last operand (only with BCD_CONVERTER_SIGNED_EN)
//   o_STATE    : FSM state, exported for observation
// Handshake: i_LOAD is a level sampled on each rising edge; it is accepted
// only when o_BUSY is low (IDLE or DONE), ignored otherwise, never queued.
// o_VALID is high for exactly one cycle per completed conversion and
// o_BCD/o_OVERFLOW are stable from that cycle until the next o_VALID.
// Modports: master = operand source, slave = converter.
interface bcd_converter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DIGITS     = 6
);
    logic [DATA_WIDTH-1:0] i_BUS;
    logic                  i_LOAD;
    logic                  o_BUSY;
    logic                  o_VALID;
    logic [4*DIGITS-1:0]   o_BCD;
    logic                  o_OVERFLOW;
    bcd_pkg::state_t       o_STATE;
`ifdef BCD_CONVERTER_SIGNED_EN
    logic                  o_NEGATIVE;

    modport master (
        output i_BUS, i_LOAD,
        input  o_BUSY, o_VALID, o_BCD, o_OVERFLOW, o_STATE, o_NEGATIVE
    );
    modport slave (
        input  i_BUS, i_LOAD,
        output o_BUSY, o_VALID, o_BCD, o_OVERFLOW, o_STATE, o_NEGATIVE
    );
`else
    modport master (
        output i_BUS, i_LOAD,
        input  o_BUSY, o_VALID, o_BCD, o_OVERFLOW, o_STATE
    );
    modport slave (
        input  i_BUS, i_LOAD,
        output o_BUSY, o_VALID, o_BCD, o_OVERFLOW, o_STATE
    );
`endif
endinterface

// File: rtl/bcd_digit_adjust.sv
// Combinational double-dabble cell: a nibble of 5 or more gets +3 so that
// the following left shift carries correctly into the next decimal digit.
//   nib_i : nibble before adjustment
//   nib_o : nibble after adjustment
module bcd_digit_adjust
    import bcd_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [3:0] nib_o
);

    always_comb begin
        nib_o = nib_i;
        if (nib_i >= BCD_ADJ_THRESHOLD) begin
            nib_o = nib_i + BCD_ADJ_ADD;
        end
    end

endmodule

// File: rtl/bcd_converter.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Feeds the seven-segment stage so that it displays decimal.
//   i_SYS_CLOCK : system clock
//   i_RESET_n   : synchronous active-low reset
//   bus         : bcd_converter_if slave (operand, load, busy, valid,
//                 result, overflow, state; plus o_NEGATIVE when the
//                 BCD_CONVERTER_SIGNED_EN macro is defined)
// With BCD_CONVERTER_SIGNED_EN the operand is two's complement and its
// magnitude is converted; the sign is reported on o_NEGATIVE.
module bcd_converter
    import bcd_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DIGITS     = 6
) (
    input  logic            i_SYS_CLOCK,
    input  logic            i_RESET_n,
    bcd_converter_if.slave  bus
);

    // One extra nibble above the result digits catches overflow.
    localparam int SW = 4 * DIGITS + 4;
    localparam int CW = cnt_width(DATA_WIDTH);

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] opnd_q, opnd_d;
    logic [SW-1:0]         scratch_q, scratch_d;
    logic [4*DIGITS-1:0]   bcd_q, bcd_d;
    logic                  ovf_q, ovf_d;
    logic                  neg_pend_q, neg_pend_d;
    logic                  neg_q, neg_d;

    logic [SW-1:0]         adj;
    logic [SW-1:0]         shifted;
    logic [DATA_WIDTH-1:0] load_mag;
    logic                  load_sign;
    logic                  unused_adj_msb;

    for (genvar g = 0; g <= DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .nib_i (scratch_q[4*g +: 4]),
            .nib_o (adj[4*g +: 4])
        );
    end

    // Adjusted scratch shifted left, operand MSB entering at bit 0.
    assign shifted        = {adj[SW-2:0], opnd_q[DATA_WIDTH-1]};
    assign unused_adj_msb = adj[SW-1];

`ifdef BCD_CONVERTER_SIGNED_EN
    // Negating in DATA_WIDTH bits maps the most negative value onto its
    // correct unsigned magnitude (e.g. 8'h80 stays 8'h80 = 128).
    assign load_sign = bus.i_BUS[DATA_WIDTH-1];
    assign load_mag  = load_sign ? (~bus.i_BUS + 1'b1) : bus.i_BUS;
`else
    assign load_sign = 1'b0;
    assign load_mag  = bus.i_BUS;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        opnd_d     = opnd_q;
        scratch_d  = scratch_q;
        bcd_d      = bcd_q;
        ovf_d      = ovf_q;
        neg_pend_d = neg_pend_q;
        neg_d      = neg_q;

        case (state_q)
            IDLE, DONE: begin
                if (bus.i_LOAD) begin
                    state_d    = SHIFT;
                    opnd_d     = load_mag;
                    scratch_d  = '0;
                    cnt_d      = CW'(DATA_WIDTH);
                    neg_pend_d = load_sign;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                scratch_d = shifted;
                opnd_d    = opnd_q << 1;
                cnt_d     = cnt_q - CW'(1);
                // Last shift: publish the post-shift scratch as DONE is entered.
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                    neg_d   = neg_pend_q;
                    if (shifted[SW-1 -: 4] == 4'd0) begin
                        bcd_d = shifted[4*DIGITS-1:0];
                        ovf_d = 1'b0;
                    end else begin
                        bcd_d = {DIGITS{BCD_NINE}};
                        ovf_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_SYS_CLOCK) begin
        if (!i_RESET_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            opnd_q     <= '0;
            scratch_q  <= '0;
            bcd_q      <= '0;
            ovf_q      <= 1'b0;
            neg_pend_q <= 1'b0;
            neg_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            opnd_q     <= opnd_d;
            scratch_q  <= scratch_d;
            bcd_q      <= bcd_d;
            ovf_q      <= ovf_d;
            neg_pend_q <= neg_pend_d;
            neg_q      <= neg_d;
        end
    end

    // Status outputs decode the state register only; no input reaches them.
    assign bus.o_BUSY     = (state_q == SHIFT);
    assign bus.o_VALID    = (state_q == DONE);
    assign bus.o_BCD      = bcd_q;
    assign bus.o_OVERFLOW = ovf_q;
    assign bus.o_STATE    = state_q;
`ifdef BCD_CONVERTER_SIGNED_EN
    assign bus.o_NEGATIVE = neg_q;
`else
    logic unused_neg;
    assign unused_neg = neg_q;
`endif

endmodule

// File: tb/tb_bcd_converter.sv
// Directed bench for bcd_converter: a 6-digit instance (main) and a
// 2-digit instance (small) share clock and reset.
module tb_bcd_converter;
    import bcd_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bcd_converter_if #(.DATA_WIDTH(8), .DIGITS(6)) bm ();
    bcd_converter_if #(.DATA_WIDTH(8), .DIGITS(2)) bs ();

    bcd_converter #(.DATA_WIDTH(8), .DIGITS(6)) dut_main (
        .i_SYS_CLOCK (clk),
        .i_RESET_n   (rst_n),
        .bus         (bm.slave)
    );

    bcd_converter #(.DATA_WIDTH(8), .DIGITS(2)) dut_small (
        .i_SYS_CLOCK (clk),
        .i_RESET_n   (rst_n),
        .bus         (bs.slave)
    );

    int checks = 0;
    int passed = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Load v into one instance (sel 0 = main, 1 = small) and wait for o_VALID.
    // lat counts falling edges after the accepting rising edge; valid is seen
    // at the 9th, i.e. the consumer captures it 9 clocks after the load edge.
    task automatic run(input int sel, input logic [7:0] v, output int lat, output int busy_n);
        @(negedge clk);
        if (sel == 0) begin bm.i_BUS = v; bm.i_LOAD = 1'b1; end
        else          begin bs.i_BUS = v; bs.i_LOAD = 1'b1; end
        @(negedge clk);
        bm.i_LOAD = 1'b0;
        bs.i_LOAD = 1'b0;
        lat    = 1;
        busy_n = (sel == 0) ? int'(bm.o_BUSY) : int'(bs.o_BUSY);
        while (!((sel == 0) ? bm.o_VALID : bs.o_VALID) && lat < 40) begin
            @(negedge clk);
            lat++;
            if ((sel == 0) ? bm.o_BUSY : bs.o_BUSY) busy_n++;
        end
    endtask

    int lat, busy_n, pulses;

    initial begin
        bm.i_BUS = '0; bm.i_LOAD = 1'b0;
        bs.i_BUS = '0; bs.i_LOAD = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_bcd",   32'(bm.o_BCD), 32'h0);
        check("rst_valid", 32'(bm.o_VALID), 32'h0);
        check("rst_busy",  32'(bm.o_BUSY), 32'h0);
        check("rst_ovf",   32'(bm.o_OVERFLOW), 32'h0);
        check("rst_state", 32'(bm.o_STATE), 32'(IDLE));
        check("rst_small_ovf", 32'(bs.o_OVERFLOW), 32'h0);
`ifdef BCD_CONVERTER_SIGNED_EN
        check("rst_neg", 32'(bm.o_NEGATIVE), 32'h0);
`endif
        rst_n = 1'b1;

        run(0, 8'd0, lat, busy_n);
        check("zero_lat", 32'(lat), 32'd9);
        check("zero_bcd", 32'(bm.o_BCD), 32'h000000);
        check("zero_ovf", 32'(bm.o_OVERFLOW), 32'h0);

        run(0, 8'd255, lat, busy_n);
        check("ff_lat",  32'(lat), 32'd9);
        check("ff_busy", 32'(busy_n), 32'd8);
`ifdef BCD_CONVERTER_SIGNED_EN
        check("ff_bcd", 32'(bm.o_BCD), 32'h000001);
        check("ff_neg", 32'(bm.o_NEGATIVE), 32'h1);
`else
        check("ff_bcd", 32'(bm.o_BCD), 32'h000255);
`endif
        @(negedge clk);
        check("valid_one_cycle", 32'(bm.o_VALID), 32'h0);

        // Load 42, then pulse a load of 99 mid-conversion: must be ignored.
        @(negedge clk);
        bm.i_BUS = 8'd42; bm.i_LOAD = 1'b1;
        @(negedge clk);
        bm.i_LOAD = 1'b0;
        @(negedge clk);
`ifdef BCD_CONVERTER_SIGNED_EN
        check("hold_during_shift", 32'(bm.o_BCD), 32'h000001);
`else
        check("hold_during_shift", 32'(bm.o_BCD), 32'h000255);
`endif
        bm.i_BUS = 8'd99; bm.i_LOAD = 1'b1;
        @(negedge clk);
        bm.i_LOAD = 1'b0;
        pulses = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (bm.o_VALID) pulses++;
        end
        check("ignore_pulses", 32'(pulses), 32'd1);
        check("ignore_bcd",    32'(bm.o_BCD), 32'h000042);

        // Back-to-back: i_LOAD held high, operand 1 then 2.
        @(negedge clk);
        bm.i_BUS = 8'd1; bm.i_LOAD = 1'b1;
        @(negedge clk);
        bm.i_BUS = 8'd2;
        lat = 1;
        while (!bm.o_VALID && lat < 40) begin @(negedge clk); lat++; end
        check("b2b_first_lat", 32'(lat), 32'd9);
        check("b2b_first_bcd", 32'(bm.o_BCD), 32'h000001);
        @(negedge clk);
        lat = 1;
        check("b2b_busy_again", 32'(bm.o_BUSY), 32'h1);
        check("b2b_hold",       32'(bm.o_BCD), 32'h000001);
        while (!bm.o_VALID && lat < 40) begin @(negedge clk); lat++; end
        bm.i_LOAD = 1'b0;
        check("b2b_spacing",    32'(lat), 32'd9);
        check("b2b_second_bcd", 32'(bm.o_BCD), 32'h000002);
        @(negedge clk);
        check("b2b_idle", 32'(bm.o_STATE), 32'(IDLE));

        // Reset after three shifts of a load of 200: aborted, no valid.
        @(negedge clk);
        bm.i_BUS = 8'd200; bm.i_LOAD = 1'b1;
        @(negedge clk);
        bm.i_LOAD = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_busy", 32'(bm.o_BUSY), 32'h1);
        rst_n = 1'b0;
        pulses = 0;
        repeat (2) begin @(negedge clk); if (bm.o_VALID) pulses++; end
        rst_n = 1'b1;
        check("abort_bcd",  32'(bm.o_BCD), 32'h0);
        check("abort_busy", 32'(bm.o_BUSY), 32'h0);
        check("abort_ovf",  32'(bm.o_OVERFLOW), 32'h0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bm.o_VALID) pulses++;
        end
        check("abort_no_valid", 32'(pulses), 32'd0);

        // Two-digit instance: saturation and overflow flag.
        run(1, 8'd99, lat, busy_n);
        check("s99_bcd", 32'(bs.o_BCD), 32'h99);
        check("s99_ovf", 32'(bs.o_OVERFLOW), 32'h0);
        run(1, 8'd100, lat, busy_n);
        check("s100_lat", 32'(lat), 32'd9);
        check("s100_bcd", 32'(bs.o_BCD), 32'h99);
        check("s100_ovf", 32'(bs.o_OVERFLOW), 32'h1);
        run(1, 8'd7, lat, busy_n);
        check("s7_bcd", 32'(bs.o_BCD), 32'h07);
        check("s7_ovf", 32'(bs.o_OVERFLOW), 32'h0);

`ifdef BCD_CONVERTER_SIGNED_EN
        run(0, 8'hFF, lat, busy_n);
        check("sg_ff_bcd", 32'(bm.o_BCD), 32'h000001);
        check("sg_ff_neg", 32'(bm.o_NEGATIVE), 32'h1);
        run(0, 8'h80, lat, busy_n);
        check("sg_80_bcd", 32'(bm.o_BCD), 32'h000128);
        check("sg_80_neg", 32'(bm.o_NEGATIVE), 32'h1);
        run(0, 8'h7F, lat, busy_n);
        check("sg_7f_bcd", 32'(bm.o_BCD), 32'h000127);
        check("sg_7f_neg", 32'(bm.o_NEGATIVE), 32'h0);
`endif

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
